// File: rtl/norm_5d_core_pkg.sv
// Shared definitions for the 5-element vector normaliser: FSM encoding,
// fixed-point constants and the element-slice helper.
package norm_5d_core_pkg;

  localparam int N_ELEM         = 5;
  localparam int ELEM_W         = 32;
  localparam int VEC_W          = N_ELEM * ELEM_W;
  localparam int IDX_W          = 3;
  localparam int QUAD_W         = 2;
  localparam int PRESCALE_SHIFT = 2;

  localparam logic [ELEM_W-1:0] Q16_ONE = 32'h0001_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEC_ISSUE,
    S_VEC_WAIT,
    S_ROT_ISSUE,
    S_ROT_WAIT,
    S_DONE
  } state_t;

  function automatic logic [ELEM_W-1:0] elem_slice(input logic [VEC_W-1:0] v,
                                                   input logic [IDX_W-1:0] idx);
    return v[ELEM_W*idx +: ELEM_W];
  endfunction

endpackage

// File: rtl/norm_5d_core.sv
// Sequences a shared CORDIC to normalise a 5-element Q15.16 vector to unit length.
// Optional NORM5D_ZERO_BYPASS_EN: an all-zero input skips the CORDIC and returns zero.
module norm_5d_core
  import norm_5d_core_pkg::*;
#(
  parameter int DIMENSIONS    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CORDIC_WIDTH  = 38,
  parameter int CORDIC_STAGES = 16,
  parameter int ANGLE_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic                             start,
  input  logic [DIMENSIONS*DATA_WIDTH-1:0] w_in,
  output logic [DIMENSIONS*DATA_WIDTH-1:0] W_out,
  output logic                             done,
  output logic                             cordic_nrst,
  output logic                             ica_cordic_vec_en,
  output logic [DATA_WIDTH-1:0]            ica_cordic_vec_xin,
  output logic [DATA_WIDTH-1:0]            ica_cordic_vec_yin,
  output logic                             ica_cordic_vec_angle_calc_en,
  output logic                             ica_cordic_rot1_en,
  output logic [DATA_WIDTH-1:0]            ica_cordic_rot1_xin,
  output logic [DATA_WIDTH-1:0]            ica_cordic_rot1_yin,
  output logic [CORDIC_STAGES-1:0]         ica_cordic_rot1_microRot_in,
  output logic [QUAD_W-1:0]                ica_cordic_rot1_quad_in,
  output logic                             ica_cordic_rot1_angle_microRot_n,
  output logic                             ica_cordic_rot1_microRot_ext_vld,
  input  logic                             cordic_vec_opvld,
  input  logic [DATA_WIDTH-1:0]            cordic_vec_xout,
  input  logic [CORDIC_STAGES-1:0]         cordic_vec_microRot_out,
  input  logic [QUAD_W-1:0]                cordic_vec_quad_out,
  input  logic                             cordic_vec_microRot_out_start,
  input  logic [ANGLE_WIDTH-1:0]           cordic_vec_angle_out,
  input  logic                             cordic_rot1_opvld,
  input  logic [DATA_WIDTH-1:0]            cordic_rot1_xout,
  input  logic [DATA_WIDTH-1:0]            cordic_rot1_yout
);

`ifdef NORM5D_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  state_t                    r_state;
  state_t                    w_state_next;
  logic [IDX_W-1:0]          r_k;
  logic [1:0]                w_mi;
  logic [DATA_WIDTH-1:0]     r_rad;
  logic [DATA_WIDTH-1:0]     r_c;
  logic [DATA_WIDTH-1:0]     r_e     [DIMENSIONS];
  logic [DATA_WIDTH-1:0]     r_w     [DIMENSIONS];
  logic [DATA_WIDTH-1:0]     r_w_out [DIMENSIONS];
  logic [CORDIC_STAGES-1:0]  r_mrot  [4];
  logic [QUAD_W-1:0]         r_quad  [4];
  logic                      r_done;
  logic                      r_cordic_nrst;
  logic [DATA_WIDTH-1:0]     w_elem_in [DIMENSIONS];
  logic                      w_in_zero;
  logic                      w_unused;

  // Prescale by 4 so sqrt(5) * full-scale still fits Q15.16.
  for (genvar gi = 0; gi < DIMENSIONS; gi++) begin : g_elem
    assign w_elem_in[gi] = DATA_WIDTH'($signed(elem_slice(w_in, IDX_W'(gi))) >>> PRESCALE_SHIFT);
    assign W_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_w_out[gi];
  end

  assign w_in_zero = (w_in == '0);
  assign w_mi      = r_k[1:0] - 2'd1;
  assign w_unused  = ^{cordic_vec_microRot_out_start, cordic_vec_angle_out, 1'(CORDIC_WIDTH)};

  assign done                             = r_done;
  assign cordic_nrst                      = r_cordic_nrst;
  assign ica_cordic_vec_xin               = r_rad;
  assign ica_cordic_vec_yin               = r_e[r_k];
  assign ica_cordic_vec_angle_calc_en     = 1'b0;
  assign ica_cordic_rot1_xin              = r_c;
  assign ica_cordic_rot1_yin              = '0;
  assign ica_cordic_rot1_microRot_in      = r_mrot[w_mi];
  assign ica_cordic_rot1_quad_in          = r_quad[w_mi];
  assign ica_cordic_rot1_angle_microRot_n = 1'b0;
  assign ica_cordic_rot1_microRot_ext_vld = ica_cordic_rot1_en;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next       = r_state;
    ica_cordic_vec_en  = 1'b0;
    ica_cordic_rot1_en = 1'b0;
    case (r_state)
      S_IDLE:      if (start) w_state_next = (ZERO_BYPASS && w_in_zero) ? S_DONE : S_VEC_ISSUE;
      S_VEC_ISSUE: begin
        ica_cordic_vec_en = 1'b1;
        w_state_next      = S_VEC_WAIT;
      end
      S_VEC_WAIT:  if (cordic_vec_opvld) w_state_next = (r_k == 3'd4) ? S_ROT_ISSUE : S_VEC_ISSUE;
      S_ROT_ISSUE: begin
        ica_cordic_rot1_en = 1'b1;
        w_state_next       = S_ROT_WAIT;
      end
      S_ROT_WAIT:  if (cordic_rot1_opvld) w_state_next = (r_k == 3'd1) ? S_DONE : S_ROT_ISSUE;
      S_DONE:      w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_k           <= '0;
      r_rad         <= '0;
      r_c           <= '0;
      r_done        <= 1'b0;
      r_cordic_nrst <= 1'b0;
      for (int i = 0; i < DIMENSIONS; i++) begin
        r_e[i]     <= '0;
        r_w[i]     <= '0;
        r_w_out[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        r_mrot[i] <= '0;
        r_quad[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (ZERO_BYPASS && w_in_zero) begin
            for (int i = 0; i < DIMENSIONS; i++) r_w[i] <= '0;
          end else begin
            r_e           <= w_elem_in;
            r_rad         <= w_elem_in[0];
            r_k           <= 3'd1;
            r_cordic_nrst <= 1'b1;
          end
        end
        S_VEC_WAIT: if (cordic_vec_opvld) begin
          r_rad        <= cordic_vec_xout;
          r_mrot[w_mi] <= cordic_vec_microRot_out;
          r_quad[w_mi] <= cordic_vec_quad_out;
          if (r_k == 3'd4) r_c <= DATA_WIDTH'(Q16_ONE);
          else             r_k <= r_k + 3'd1;
        end
        // Unwind the rotations from the last pair back to the first.
        S_ROT_WAIT: if (cordic_rot1_opvld) begin
          r_w[r_k] <= cordic_rot1_yout;
          r_c      <= cordic_rot1_xout;
          if (r_k == 3'd1) r_w[0] <= cordic_rot1_xout;
          else             r_k    <= r_k - 3'd1;
        end
        S_DONE: begin
          r_w_out       <= r_w;
          r_done        <= 1'b1;
          r_cordic_nrst <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_5d_core.sv
// Bench for norm_5d_core: behavioural CORDIC stand-in plus a real-arithmetic
// reference (e_i / |w|) for every job.
module tb_norm_5d_core;

  localparam real PI      = 3.14159265358979;
  localparam real HALF_PI = PI / 2.0;
`ifdef NORM5D_ZERO_BYPASS_EN
  localparam bit TB_BYPASS = 1'b1;
`else
  localparam bit TB_BYPASS = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         nreset = 1'b0;
  logic         start  = 1'b0;
  logic [159:0] w_in   = '0;
  logic [159:0] W_out;
  logic         done, cordic_nrst;
  logic         ica_cordic_vec_en, ica_cordic_vec_angle_calc_en;
  logic [31:0]  ica_cordic_vec_xin, ica_cordic_vec_yin;
  logic         ica_cordic_rot1_en, ica_cordic_rot1_angle_microRot_n, ica_cordic_rot1_microRot_ext_vld;
  logic [31:0]  ica_cordic_rot1_xin, ica_cordic_rot1_yin;
  logic [15:0]  ica_cordic_rot1_microRot_in;
  logic [1:0]   ica_cordic_rot1_quad_in;

  logic         cordic_vec_opvld              = 1'b0;
  logic [31:0]  cordic_vec_xout               = '0;
  logic [15:0]  cordic_vec_microRot_out       = '0;
  logic [1:0]   cordic_vec_quad_out           = '0;
  logic         cordic_vec_microRot_out_start = 1'b0;
  logic [15:0]  cordic_vec_angle_out          = '0;
  logic         cordic_rot1_opvld             = 1'b0;
  logic [31:0]  cordic_rot1_xout              = '0;
  logic [31:0]  cordic_rot1_yout              = '0;

  int checks = 0;
  int errors = 0;
  int gen    = 0;

  norm_5d_core dut (
    .clk(clk), .nreset(nreset), .start(start), .w_in(w_in), .W_out(W_out),
    .done(done), .cordic_nrst(cordic_nrst),
    .ica_cordic_vec_en(ica_cordic_vec_en),
    .ica_cordic_vec_xin(ica_cordic_vec_xin), .ica_cordic_vec_yin(ica_cordic_vec_yin),
    .ica_cordic_vec_angle_calc_en(ica_cordic_vec_angle_calc_en),
    .ica_cordic_rot1_en(ica_cordic_rot1_en),
    .ica_cordic_rot1_xin(ica_cordic_rot1_xin), .ica_cordic_rot1_yin(ica_cordic_rot1_yin),
    .ica_cordic_rot1_microRot_in(ica_cordic_rot1_microRot_in),
    .ica_cordic_rot1_quad_in(ica_cordic_rot1_quad_in),
    .ica_cordic_rot1_angle_microRot_n(ica_cordic_rot1_angle_microRot_n),
    .ica_cordic_rot1_microRot_ext_vld(ica_cordic_rot1_microRot_ext_vld),
    .cordic_vec_opvld(cordic_vec_opvld), .cordic_vec_xout(cordic_vec_xout),
    .cordic_vec_microRot_out(cordic_vec_microRot_out), .cordic_vec_quad_out(cordic_vec_quad_out),
    .cordic_vec_microRot_out_start(cordic_vec_microRot_out_start),
    .cordic_vec_angle_out(cordic_vec_angle_out),
    .cordic_rot1_opvld(cordic_rot1_opvld), .cordic_rot1_xout(cordic_rot1_xout),
    .cordic_rot1_yout(cordic_rot1_yout)
  );

  always #5 clk = ~clk;
  always @(negedge nreset) gen++;

  // Vectoring stand-in: gain-free magnitude, angle split into quadrant + fraction word.
  always @(negedge clk) begin : vec_model
    int  g, lat, q, m;
    real xr, yr, th, ph;
    if (nreset === 1'b1 && ica_cordic_vec_en === 1'b1) begin
      g  = gen;
      xr = $itor($signed(ica_cordic_vec_xin));
      yr = $itor($signed(ica_cordic_vec_yin));
      th = $atan2(yr, xr);
      if (th < 0.0) th = th + 2.0 * PI;
      q = int'($floor(th / HALF_PI));
      if (q > 3) q = 3;
      if (q < 0) q = 0;
      ph = th - q * HALF_PI;
      m  = int'(ph / HALF_PI * 65536.0);
      if (m > 65535) m = 65535;
      if (m < 0) m = 0;
      lat = $urandom_range(1, 5);
      repeat (lat) @(posedge clk);
      #1;
      if (g == gen && nreset === 1'b1 && cordic_nrst === 1'b1) begin
        cordic_vec_xout         = 32'(int'($sqrt(xr * xr + yr * yr)));
        cordic_vec_microRot_out = 16'(m);
        cordic_vec_quad_out     = 2'(q);
        cordic_vec_opvld        = 1'b1;
        @(posedge clk);
        #1;
        cordic_vec_opvld = 1'b0;
      end
    end
  end

  // Rotation stand-in: rotates (x, y) by the angle encoded in quadrant + fraction word.
  always @(negedge clk) begin : rot_model
    int  g, lat;
    real xr, yr, th;
    if (nreset === 1'b1 && ica_cordic_rot1_en === 1'b1) begin
      g  = gen;
      xr = $itor($signed(ica_cordic_rot1_xin));
      yr = $itor($signed(ica_cordic_rot1_yin));
      th = $itor(ica_cordic_rot1_quad_in) * HALF_PI
         + $itor(ica_cordic_rot1_microRot_in) / 65536.0 * HALF_PI;
      lat = $urandom_range(1, 5);
      repeat (lat) @(posedge clk);
      #1;
      if (g == gen && nreset === 1'b1 && cordic_nrst === 1'b1) begin
        cordic_rot1_xout  = 32'(int'(xr * $cos(th) - yr * $sin(th)));
        cordic_rot1_yout  = 32'(int'(xr * $sin(th) + yr * $cos(th)));
        cordic_rot1_opvld = 1'b1;
        @(posedge clk);
        #1;
        cordic_rot1_opvld = 1'b0;
      end
    end
  end

  function automatic int to_q(input real r);
    return int'(r * 65536.0);
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tolerance 2^-10 = 64 LSB of Q15.16.
  task automatic check_near(input string tag, input logic [31:0] obs, input real exp_lsb);
    real diff;
    bit  ok;
    diff = $itor($signed(obs)) - exp_lsb;
    if (diff < 0.0) diff = -diff;
    ok = (diff <= 64.0);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (+/-64 lsb)", tag, $signed(obs), int'(exp_lsb));
    end
  endtask

  task automatic check_result(input string name, input int wq[5], input real nrm);
    for (int i = 0; i < 5; i++)
      check_near($sformatf("%s_W%0d", name, i), W_out[32*i +: 32], $itor(wq[i]) / nrm * 65536.0);
  endtask

  task automatic run_job(input string name, input int wq[5], input bit poke_busy);
    real  nrm;
    int   cycles, extra;
    logic got_done;
    bit   is_zero;
    nrm = 0.0;
    for (int i = 0; i < 5; i++) nrm = nrm + $itor(wq[i]) * $itor(wq[i]);
    nrm     = $sqrt(nrm);
    is_zero = (nrm == 0.0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) w_in[32*i +: 32] = wq[i];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!(TB_BYPASS && is_zero)) check_bit({name, "_nrst_busy"}, cordic_nrst, 1'b1);
    cycles   = 1;
    got_done = done;
    while (got_done !== 1'b1 && cycles < 1000) begin
      if (poke_busy && cycles == 5) begin
        start = 1'b1;
        w_in  = ~w_in;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      got_done = done;
    end
    start = 1'b0;
    check_bit({name, "_done"}, got_done, 1'b1);
    if (got_done === 1'b1) begin
      check_bit({name, "_nrst_idle"}, cordic_nrst, 1'b0);
      if (!is_zero) check_result(name, wq, nrm);
      if (TB_BYPASS && is_zero) begin
        check_vec({name, "_zero_out"}, W_out, '0);
        check_int({name, "_bypass_latency"}, cycles, 2);
      end
      @(posedge clk);
      #1;
      check_bit({name, "_done_single"}, done, 1'b0);
      $display("job %s: cycles=%0d W_out=%h", name, cycles, W_out);
      if (poke_busy) begin
        extra = 0;
        repeat (20) begin
          @(posedge clk);
          #1;
          if (done === 1'b1) extra++;
        end
        check_int({name, "_no_restart"}, extra, 0);
        check_result({name, "_hold"}, wq, nrm);
      end
    end else begin
      $display("job %s: no completion within %0d cycles", name, cycles);
    end
  endtask

  initial begin
    int v[5];
    int n, tmp, mx;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_W_out", W_out, '0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_cordic_nrst", cordic_nrst, 1'b0);
    check_bit("rst_vec_en", ica_cordic_vec_en, 1'b0);
    check_bit("rst_rot1_en", ica_cordic_rot1_en, 1'b0);
    check_bit("rst_angle_calc_en", ica_cordic_vec_angle_calc_en, 1'b0);
    check_bit("rst_angle_microRot_n", ica_cordic_rot1_angle_microRot_n, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(posedge clk);

    v = '{to_q(3.0), to_q(4.0), 0, 0, 0};
    run_job("p345", v, 1'b0);
    v = '{0, 0, to_q(4.0), 0, to_q(3.0)};
    run_job("zero_pair", v, 1'b0);
    v = '{to_q(5.0), to_q(20.0), to_q(-4.0), 0, to_q(3.0)};
    run_job("mixed", v, 1'b0);
    v = '{to_q(0.03125), to_q(-45.75), to_q(123.25), to_q(-0.5), to_q(32767.0)};
    run_job("big_pos", v, 1'b0);
    v = '{to_q(16.75), to_q(-0.25), to_q(2500.5), 1, to_q(-32768.0)};
    run_job("big_neg", v, 1'b0);

    for (int r = 0; r < 4; r++) begin
      mx = 0;
      for (int i = 0; i < 5; i++) begin
        tmp  = int'($urandom);
        v[i] = tmp >>> $urandom_range(0, 16);
        if ((v[i] < 0 ? -v[i] : v[i]) > mx) mx = (v[i] < 0 ? -v[i] : v[i]);
      end
      if (mx < 65536) v[0] = 65536 + int'($urandom_range(0, 65535));
      run_job($sformatf("rand%0d", r), v, 1'b0);
    end

    // Start while busy must be ignored.
    v = '{to_q(5.0), to_q(20.0), to_q(-4.0), 0, to_q(3.0)};
    run_job("busy_poke", v, 1'b1);

    // Abort mid-rotation with async reset, then recover.
    @(negedge clk);
    for (int i = 0; i < 5; i++) w_in[32*i +: 32] = v[i];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (ica_cordic_rot1_en !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_bit("abort_reached_rot", ica_cordic_rot1_en, 1'b1);
    #2;
    nreset = 1'b0;
    #1;
    check_vec("abort_W_out", W_out, '0);
    check_bit("abort_done", done, 1'b0);
    check_bit("abort_cordic_nrst", cordic_nrst, 1'b0);
    check_bit("abort_rot1_en", ica_cordic_rot1_en, 1'b0);
    check_bit("abort_vec_en", ica_cordic_vec_en, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    v = '{to_q(3.0), to_q(4.0), 0, 0, 0};
    run_job("after_abort", v, 1'b0);

    v = '{0, 0, 0, 0, 0};
    run_job("all_zero", v, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/norm_5d_core.md
Name: norm_5d_core

Overview:
- Normalises a 5-component Q15.16 vector w to unit length, W = w/|w|, using an external shared CORDIC (SCICA_CORDIC_wrapper, ICA vectoring and rotation-1 channels).
- Sits in the FastICA weight-update path and only sequences the CORDIC; it contains no multipliers or dividers.

Parameters:
DIMENSIONS, 5, vector length (fixed at 5)
DATA_WIDTH, 32, Q15.16 signed element width
CORDIC_WIDTH, 38, internal CORDIC width (pass-through only)
CORDIC_STAGES, 16, micro-rotation word width
ANGLE_WIDTH, 16, vectoring angle width

Ports:
clk  in  1  clock
nreset  in  1  async active-low reset
start  in  1  job request (level, sampled in IDLE)
w_in  in  160  element i at [32i+31:32i]
W_out  out  160  normalised vector, same packing
done  out  1  one-cycle completion pulse
cordic_nrst  out  1  CORDIC reset: low in IDLE, high while busy
ica_cordic_vec_en  out  1  vectoring issue pulse
ica_cordic_vec_xin/yin  out  32 each  vectoring operands
ica_cordic_vec_angle_calc_en  out  1  tied 0
ica_cordic_rot1_en  out  1  rotation issue pulse
ica_cordic_rot1_xin/yin  out  32 each  rotation operands
ica_cordic_rot1_microRot_in  out  16  stored micro-rotation word
ica_cordic_rot1_quad_in  out  2  stored quadrant
ica_cordic_rot1_angle_microRot_n  out  1  tied 0 (micro-rotation mode)
ica_cordic_rot1_microRot_ext_vld  out  1  high with rot1_en
cordic_vec_opvld, cordic_vec_xout(32), cordic_vec_microRot_out(16), cordic_vec_quad_out(2), cordic_vec_microRot_out_start, cordic_vec_angle_out(16)  in  vectoring results (start/angle ignored)
cordic_rot1_opvld, cordic_rot1_xout(32), cordic_rot1_yout(32)  in  rotation results

Behaviour:
- Reset: state IDLE; W_out=0, done=0, all enables 0, cordic_nrst=0, stored words cleared.
- IDLE, start=1: latch w_in arithmetically shifted right by 2 (headroom; sqrt(5)*2^15 must fit); go to VEC.
- VEC k=1..4: pulse vec_en for one cycle with x=r(k-1), y=e_k, where r0=e0. Wait for vec_opvld; capture r_k=vec_xout, M_k=microRot_out, Q_k=quad_out. r4 is |w|/4.
- ROT k=4..1: pulse rot1_en with microRot_ext_vld=1, microRot_in=M_k, quad_in=Q_k, x=c, y=0.
  - c starts at 1.0 (32'h00010000).
  - On rot1_opvld: W[k]=yout and c=xout.
  - After k=1, W[0]=c.
- CORDIC outputs are gain-compensated by the wrapper; no scale correction here.
- DONE: W_out updated from W[], done=1 for exactly one cycle, then IDLE.
- W_out holds until the next job's DONE.
- cordic_nrst rises the cycle after start is accepted and falls on return to IDLE.
- Only one CORDIC op is outstanding at a time; opvld outside a wait state is ignored.
- start while busy is ignored. Async reset mid-job aborts to IDLE with outputs cleared.
- Negative elements and -32768.0 are handled via quadrant words.
- Zero pairs (r=0) are legal: the downstream component then scales to 0 regardless of M_k.
- Accuracy: each element within 2^-10 of the ideal value.

Optional Feature:
- NORM5D_ZERO_BYPASS_EN defined: an all-zero w_in skips the CORDIC, and W_out=0 with done pulsing 2 cycles after start.
- Undefined: zero input runs the normal sequence; W_out is unspecified, but done still pulses.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, VEC_ISSUE, VEC_WAIT, ROT_ISSUE, ROT_WAIT, DONE);
  - Q16_ONE constant;
  - PRESCALE_SHIFT=2;
  - element-slice helper widths.
- No sub-module: a single FSM plus 4x(16+2)-bit microRot/quad store and 5x32 result registers.

Test Plan:
- w=(3,4,0,0,0) with e0=3 -> W=(0.6,0.8,0,0,0) ±2^-10; done single pulse; record cycle count.
- w=(0,0,4,0,3) -> (0,0,0.8,0,0.6); exercises zero-pair vectoring.
- w=(5,20,-4,0,3) -> (0.2357,0.9428,-0.1886,0,0.1414).
- w=(0.03125,-45.75,123.25,-0.5,32767) and (16.75,-0.25,2500.5,2^-16,-32768) -> no overflow; dominant element ≈±0.997..1.0, others proportional.
- Assert nreset mid-ROT, then restart with (3,4,0,0,0) -> correct result; outputs zero during reset.
- Pulse start while busy -> ignored, and the current result is unchanged.
